multibyte_add_sequencer: RTL
============================

# multibyte_add_sequencer

Byte-serial multi-precision adder controller. Accepts two `NBYTES`-byte operands and a carry-in, then sequences one shared 8-bit adder slice across the bytes, least-significant byte first, chaining the carry through a register. It produces the full-width sum and carry-out with a one-cycle `done` pulse. It sits between a requesting datapath and the 8-bit adding resource, so arbitrary-width additions reuse a single byte adder.

## Interface
- `NBYTES`, default 4: operand width in bytes; must be ≥ 1. Total width W = 8·NBYTES.
- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request. Accepted only on a rising edge where `busy`=0.
- `a`, input, W: operand A. Sampled on the accepting edge.
- `b`, input, W: operand B. Sampled on the accepting edge.
- `cin`, input, 1: carry-in to byte 0. Sampled on the accepting edge.
- `sub`, input, 1: present only with `MADD_SUB_EN`. Selects subtraction. Sampled on the accepting edge.
- `busy`, output, 1: high while bytes are being processed.
- `done`, output, 1: one-cycle pulse; `sum`/`cout` are final during this cycle.
- `sum`, output, W: result register.
- `cout`, output, 1: carry out of the MSB byte.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE →RUN on `start`.
  - RUN →DONE after the byte with index NBYTES−1.
  - DONE →RUN if `start`, else →IDLE.
- On accept:
  - latch `a`, `b` and the carry (`cin`) into internal registers;
  - clear byte index `idx`=0;
  - leave `sum` unchanged.
- Each RUN cycle:
  - byte adder computes `a[idx] + b[idx] + carry` (9-bit result);
  - bits [7:0] are written to `sum[8·idx +: 8]`;
  - bit 8 is written to the carry register;
  - `idx` increments.
- `idx` never wraps inside a run. It counts 0…NBYTES−1 only.
- `cout` is updated from the carry register on entry to DONE and holds until the next DONE.
- `busy`=1 in RUN only. `done`=1 in DONE only.
- `start` while `busy`=1 is ignored: no latch, no error, no effect on the current run.
- `start` during the DONE cycle is accepted. This gives back-to-back operation with no bubble beyond DONE.
- `sum` bytes are overwritten progressively during a run. `sum` is valid only in the `done` cycle and holds until the first RUN write of the next operation.
- Reset values: `busy`=0, `done`=0, `sum`=0, `cout`=0, state IDLE, `idx`=0, carry=0.
- `rst` mid-run aborts immediately to the reset values. The partial sum is discarded.
- `rst` together with `start` on the same edge: reset wins and `start` is dropped.

## Timing
- Accepting edge E (`start`=1, `busy`=0).
- Byte i is written at edge E+1+i.
- `done`=1 for the cycle following edge E+NBYTES.
- Latency: NBYTES cycles from the accepting edge to `done`.
- Throughput: one operation per NBYTES+1 cycles.
- NBYTES=1: a single RUN cycle, then DONE.
- All outputs are registered. The byte adder path is combinational within one cycle: 8-bit add plus mux selection on `idx`.

## Configuration
- `MADD_SUB_EN` defined:
  - `sub` port exists.
  - With `sub`=1, B bytes are inverted before the adder and the initial carry is forced to 1 (`cin` ignored). The result is a − b mod 2^W.
  - `cout`=1 means no borrow (a ≥ b unsigned).
  - With `sub`=0, behaviour is identical to the undefined case.
- `MADD_SUB_EN` undefined: no `sub` port and no inversion logic. The block is add-only.

## Structure
- Package `madd_pkg`: `BYTE_W`=8, and the state enum `madd_state_t` {IDLE, RUN, DONE}.
- Sub-module `byte_adder`: 8-bit `a`, 8-bit `b`, `cin` → 8-bit `sum`, `cout`, implemented as a single 9-bit add.
- `multibyte_add_sequencer` instantiates exactly one `byte_adder` and holds the FSM, `idx`, the carry register and the operand/sum registers.

## Test plan
All scenarios use NBYTES=4.
- Carry across a byte boundary: `a`=0x000000FF, `b`=0x00000001, `cin`=0 → `sum`=0x00000100, `cout`=0. `done` occurs exactly 4 cycles after the accepting edge, and `busy` is high for those 4 cycles.
- Full carry ripple: `a`=`b`=0xFFFFFFFF, `cin`=1 → `sum`=0xFFFFFFFF, `cout`=1.
- Start while busy: first request 0x12345678+0x11111111. Assert `start` with different operands at run cycle 2 → ignored; result is 0x23456789, `cout`=0, and there is exactly one `done` pulse.
- Reset mid-run: assert `rst` at run cycle 2 → next cycle `busy`=0, `done`=0, `sum`=0, `cout`=0. A new start with 1+2 then gives `sum`=3.
- Back-to-back: second `start` held high during the `done` cycle → accepted. Its `done` arrives 4 cycles later with the correct second sum, and the first result is visible during the first `done`.
- With `MADD_SUB_EN`: `a`=5, `b`=7, `sub`=1 → `sum`=0xFFFFFFFE, `cout`=0. Then `a`=7, `b`=5, `sub`=1 → `sum`=2, `cout`=1.

Source files
------------

// File: rtl/madd_pkg.sv
// Shared constants and state type for the byte-serial multi-precision adder.
package madd_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } madd_state_t;
endpackage

// File: rtl/multibyte_add_sequencer_byte_adder.sv
// One 8-bit adder slice with carry in/out, shared across all bytes of an operation.
module byte_adder
  import madd_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              cout
);

  logic [BYTE_W:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, cin};
  assign sum   = total[BYTE_W-1:0];
  assign cout  = total[BYTE_W];

endmodule

// File: rtl/multibyte_add_sequencer.sv
// Byte-serial NBYTES-wide adder: walks one byte_adder LSB-first, chaining carry in a register.
// Optional MADD_SUB_EN adds a sub input selecting a - b (B inverted, carry forced to 1).
module multibyte_add_sequencer
  import madd_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [BYTE_W*NBYTES-1:0] a,
  input  logic [BYTE_W*NBYTES-1:0] b,
  input  logic                     cin,
`ifdef MADD_SUB_EN
  input  logic                     sub,
`endif
  output logic                     busy,
  output logic                     done,
  output logic [BYTE_W*NBYTES-1:0] sum,
  output logic                     cout
);

  // state | meaning
  // IDLE  | waiting for start, last result held
  // RUN   | one byte per cycle, idx = byte being added
  // DONE  | sum/cout final; start here chains the next operation

  localparam int W     = BYTE_W * NBYTES;
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  madd_state_t      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             sub_q, sub_d;

  logic [BYTE_W-1:0] a_byte, b_byte, add_sum;
  logic              add_cout, last_byte;

  assign a_byte    = a_q[BYTE_W*int'(idx_q) +: BYTE_W];
  assign last_byte = (idx_q == IDX_W'(NBYTES - 1));

`ifdef MADD_SUB_EN
  assign b_byte = sub_q ? ~b_q[BYTE_W*int'(idx_q) +: BYTE_W] : b_q[BYTE_W*int'(idx_q) +: BYTE_W];
`else
  assign b_byte = b_q[BYTE_W*int'(idx_q) +: BYTE_W];
`endif

  byte_adder u_byte_adder (
    .a    (a_byte),
    .b    (b_byte),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    sub_d   = sub_q;

    case (state_q)
      RUN: begin
        sum_d[BYTE_W*int'(idx_q) +: BYTE_W] = add_sum;
        carry_d = add_cout;
        if (last_byte) begin
          state_d = DONE;
          cout_d  = add_cout;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: begin
        // IDLE and DONE both accept; DONE otherwise falls back to IDLE
        if (start) begin
          state_d = RUN;
          idx_d   = '0;
          a_d     = a;
          b_d     = b;
`ifdef MADD_SUB_EN
          sub_d   = sub;
          carry_d = sub ? 1'b1 : cin;
`else
          sub_d   = 1'b0;
          carry_d = cin;
`endif
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      sub_q   <= sub_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
